// File: rtl/beamscaler_core_v3_pkg.sv
// Shared definitions for the beam scaler core.
//   STUCK_BIT / SAT_BIT : flag positions in the 32-bit read word
//   RD_LATENCY          : cycles from rd_i to rd_valid_o
//   mode_e              : per-channel counting mode
//   sat_value()         : all-ones counter value for a given width
package beamscaler_pkg;

  localparam int unsigned STUCK_BIT  = 31;
  localparam int unsigned SAT_BIT    = 30;
  localparam int unsigned RD_LATENCY = 2;

  typedef enum logic {
    MODE_EDGE  = 1'b0,
    MODE_LEVEL = 1'b1
  } mode_e;

  function automatic logic [29:0] sat_value(input int unsigned width);
    logic [29:0] v;
    v = '0;
    for (int unsigned b = 0; b < 30; b++) begin
      if (b < width) v[b] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/beamscaler_core_v3_if.sv
// Scaler readout port.
//   rd_i       : read strobe (master -> core)
//   rd_adr_i   : channel index (master -> core)
//   rd_dat_o   : read data, {stuck, sat, 0.., count} (core -> master)
//   rd_valid_o : one-cycle data-valid pulse (core -> master)
interface beamscaler_core_v3_if;
  logic        rd_i;
  logic [7:0]  rd_adr_i;
  logic [31:0] rd_dat_o;
  logic        rd_valid_o;

  modport master (output rd_i, output rd_adr_i, input rd_dat_o, input rd_valid_o);
  modport slave  (input rd_i, input rd_adr_i, output rd_dat_o, output rd_valid_o);
endinterface

// File: rtl/beamscaler_core_v3_chan.sv
// One scaler channel: input edge register, stuck run counter,
// saturating event counter and per-period sticky stuck/sat flags.
//   ifclk_i, rst_n_i : clock, async active-low reset
//   count_i, mode_i  : raw trigger level and mode (mode registered once)
//   ce_i             : stuck-check clock enable
//   timer_i          : period end; live state reloads with this cycle's event
//   cnt_o, stuck_o, sat_o : live counter and sticky flags
module beamscaler_chan
  import beamscaler_pkg::*;
#(
  parameter int unsigned CNT_WIDTH          = 10,
  parameter int unsigned STUCK_DEPTH        = 3,
  parameter bit          LEVEL_MODE_DEFAULT = 1'b0
) (
  input  logic                 ifclk_i,
  input  logic                 rst_n_i,
  input  logic                 count_i,
  input  logic                 mode_i,
  input  logic                 ce_i,
  input  logic                 timer_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 stuck_o,
  output logic                 sat_o
);

  localparam logic [CNT_WIDTH-1:0] SAT   = CNT_WIDTH'(sat_value(CNT_WIDTH));
  localparam logic [3:0]           DEPTH = 4'(STUCK_DEPTH);

  logic                 prev_q;
  mode_e                mode_q;
  logic [3:0]           run_q, run_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 stuck_q, stuck_d;
  logic                 sat_q, sat_d;
  logic                 inc;
  logic                 stuck_now;

  always_comb begin
    inc       = (mode_q == MODE_LEVEL) ? count_i : (count_i & ~prev_q);
    stuck_now = (run_q == DEPTH);

    run_d = run_q;
    if (!count_i) begin
      run_d = '0;
    end else if (ce_i && (run_q != DEPTH)) begin
      run_d = run_q + 4'd1;
    end

    // A period boundary restarts from this cycle's event so nothing is lost.
    if (stuck_now) begin
      cnt_d = SAT;
    end else if (timer_i) begin
      cnt_d = CNT_WIDTH'(inc);
    end else if (inc && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end

    stuck_d = (timer_i ? 1'b0 : stuck_q) | stuck_now;
    sat_d   = (timer_i ? 1'b0 : sat_q) | (cnt_d == SAT);
  end

  always_ff @(posedge ifclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_q  <= 1'b0;
      mode_q  <= mode_e'(LEVEL_MODE_DEFAULT);
      run_q   <= '0;
      cnt_q   <= '0;
      stuck_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      prev_q  <= count_i;
      mode_q  <= mode_e'(mode_i);
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      stuck_q <= stuck_d;
      sat_q   <= sat_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign stuck_o = stuck_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/beamscaler_core_v3.sv
// Beam scaler core: NCHAN saturating scalers with stuck detection,
// double-buffered on each integration-period boundary.
//   ifclk_i, rst_n_i : clock, async active-low reset
//   count_i, mode_i  : per-channel trigger levels and modes
//   timer_i          : period-end pulse; commits live state to bank bank_o
//   done_o           : one-cycle pulse after a commit
//   bank_o           : bank currently being written
//   rd_if            : 2-cycle pipelined readout of the completed bank
module beamscaler_core_v3
  import beamscaler_pkg::*;
#(
  parameter int unsigned NCHAN              = 92,
  parameter int unsigned CNT_WIDTH          = 10,
  parameter int unsigned STUCK_DIV          = 31,
  parameter int unsigned STUCK_DEPTH        = 3,
  parameter bit          LEVEL_MODE_DEFAULT = 1'b0
) (
  input  logic                ifclk_i,
  input  logic                rst_n_i,
  input  logic [NCHAN-1:0]    count_i,
  input  logic [NCHAN-1:0]    mode_i,
  input  logic                timer_i,
  output logic                done_o,
  output logic                bank_o,
  beamscaler_core_v3_if.slave rd_if
);

  localparam int unsigned     SW       = CNT_WIDTH + 2;
  localparam int unsigned     DW       = $clog2(STUCK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(STUCK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          ce;
  logic          done_q;
  logic          bank_q;

  logic [SW-1:0] live_word [NCHAN];
  logic [SW-1:0] snap_q    [2][NCHAN];

  logic          rd1_v_q;
  logic [7:0]    rd1_adr_q;
  logic          rd1_bank_q;
  logic [SW-1:0] sel_word;
  logic [31:0]   rd_dat_d;
  logic [31:0]   rd_dat_q;
  logic          rd_valid_q;

  always_comb begin
    ce    = (div_q == DIV_LAST);
    div_d = ce ? '0 : div_q + DW'(1);
  end

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    logic [CNT_WIDTH-1:0] cnt;
    logic                 stuck;
    logic                 sat;

    beamscaler_chan #(
      .CNT_WIDTH          (CNT_WIDTH),
      .STUCK_DEPTH        (STUCK_DEPTH),
      .LEVEL_MODE_DEFAULT (LEVEL_MODE_DEFAULT)
    ) u_chan (
      .ifclk_i (ifclk_i),
      .rst_n_i (rst_n_i),
      .count_i (count_i[g]),
      .mode_i  (mode_i[g]),
      .ce_i    (ce),
      .timer_i (timer_i),
      .cnt_o   (cnt),
      .stuck_o (stuck),
      .sat_o   (sat)
    );

    assign live_word[g] = {stuck, sat, cnt};
  end

  // Bank is latched with the request, so a commit one cycle later cannot
  // redirect an in-flight read; the commit writes the other bank anyway.
  always_comb begin
    sel_word = '0;
    for (int unsigned c = 0; c < NCHAN; c++) begin
      if (rd1_adr_q == 8'(c)) sel_word = snap_q[rd1_bank_q][c];
    end
    rd_dat_d                = '0;
    rd_dat_d[STUCK_BIT]     = sel_word[SW-1];
    rd_dat_d[SAT_BIT]       = sel_word[SW-2];
    rd_dat_d[CNT_WIDTH-1:0] = sel_word[CNT_WIDTH-1:0];
  end

  always_ff @(posedge ifclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q      <= '0;
      done_q     <= 1'b0;
      bank_q     <= 1'b0;
      rd1_v_q    <= 1'b0;
      rd1_adr_q  <= '0;
      rd1_bank_q <= 1'b0;
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      done_q     <= timer_i;
      bank_q     <= bank_q ^ timer_i;
      rd1_v_q    <= rd_if.rd_i;
      if (rd_if.rd_i) begin
        rd1_adr_q  <= rd_if.rd_adr_i;
        rd1_bank_q <= ~bank_q;
      end
      rd_valid_q <= rd1_v_q;
      if (rd1_v_q) rd_dat_q <= rd_dat_d;
    end
  end

  always_ff @(posedge ifclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snap_q <= '{default: '0};
    end else if (timer_i) begin
      for (int unsigned c = 0; c < NCHAN; c++) begin
        snap_q[bank_q][c] <= live_word[c];
      end
    end
  end

  assign done_o           = done_q;
  assign bank_o           = bank_q;
  assign rd_if.rd_dat_o   = rd_dat_q;
  assign rd_if.rd_valid_o = rd_valid_q;

endmodule

// File: tb/tb_beamscaler_core_v3.sv
module tb_beamscaler_core_v3;
  import beamscaler_pkg::*;

  localparam int unsigned NB    = 92;
  localparam int unsigned DIV   = 31;
  localparam int unsigned DEPTH = 3;

  logic       ifclk;
  logic       rst_n;
  logic [3:0] cnt_in;
  logic [3:0] mode_in;
  logic       timer;
  logic       rd;
  logic [7:0] adr;
  logic       done_a, bank_a, done_b, bank_b;

  beamscaler_core_v3_if if_a ();
  beamscaler_core_v3_if if_b ();

  assign if_a.rd_i     = rd;
  assign if_a.rd_adr_i = adr;
  assign if_b.rd_i     = rd;
  assign if_b.rd_adr_i = adr;

  beamscaler_core_v3 #(
    .NCHAN (4), .CNT_WIDTH (10), .STUCK_DIV (DIV), .STUCK_DEPTH (DEPTH), .LEVEL_MODE_DEFAULT (1'b0)
  ) dut_a (
    .ifclk_i (ifclk), .rst_n_i (rst_n), .count_i (cnt_in), .mode_i (mode_in),
    .timer_i (timer), .done_o (done_a), .bank_o (bank_a), .rd_if (if_a)
  );

  beamscaler_core_v3 #(
    .NCHAN (NB), .CNT_WIDTH (4), .STUCK_DIV (DIV), .STUCK_DEPTH (DEPTH), .LEVEL_MODE_DEFAULT (1'b0)
  ) dut_b (
    .ifclk_i (ifclk), .rst_n_i (rst_n), .count_i ({{(NB-4){1'b0}}, cnt_in}),
    .mode_i ({{(NB-4){1'b0}}, mode_in}), .timer_i (timer), .done_o (done_b),
    .bank_o (bank_b), .rd_if (if_b)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  // Reference model: instance 0 = 10-bit counters, instance 1 = 4-bit counters.
  int unsigned satv [2] = '{1023, 15};
  bit          prev [4];
  bit          meff [4];
  int unsigned high [4];
  int unsigned mcnt [2][4];
  bit          mstk [2][4];
  bit          msat [2][4];
  logic [31:0] snap [2][2][4];
  bit          mbank, mdone;
  bit          p1v, p2v;
  logic [31:0] p1d [2];
  logic [31:0] p2d [2];
  int unsigned n_edge;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input bit s, input bit a, input int unsigned c);
    logic [31:0] w;
    w     = 32'(c);
    w[31] = s;
    w[30] = a;
    return w;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      prev[c] = 0; meff[c] = 0; high[c] = 0;
      for (int k = 0; k < 2; k++) begin
        mcnt[k][c] = 0; mstk[k][c] = 0; msat[k][c] = 0;
        snap[k][0][c] = '0; snap[k][1][c] = '0;
      end
    end
    mbank = 0; mdone = 0; p1v = 0; p2v = 0;
    p1d = '{default: '0}; p2d = '{default: '0};
    n_edge = 0;
  endtask

  // Applies one clock edge worth of behaviour using the inputs currently driven.
  task automatic model_edge();
    bit          ce, lvl, ev, stk_now;
    int unsigned base, nxt;
    logic [31:0] rdv [2];
    ce = (n_edge % DIV) == (DIV - 1);
    for (int k = 0; k < 2; k++)
      rdv[k] = (adr < 8'd4) ? snap[k][!mbank][adr[1:0]] : 32'h0;
    p2v = p1v; p2d = p1d;
    p1v = rd;  p1d = rdv;
    for (int c = 0; c < 4; c++) begin
      lvl     = cnt_in[c];
      ev      = meff[c] ? lvl : (lvl && !prev[c]);
      stk_now = high[c] >= DEPTH;
      for (int k = 0; k < 2; k++) begin
        if (timer) begin
          snap[k][mbank][c] = mk(mstk[k][c], msat[k][c], mcnt[k][c]);
          base = 0; mstk[k][c] = 0; msat[k][c] = 0;
        end else begin
          base = mcnt[k][c];
        end
        nxt = base + 32'(ev);
        mcnt[k][c] = stk_now ? satv[k] : ((nxt > satv[k]) ? satv[k] : nxt);
        mstk[k][c] = mstk[k][c] | stk_now;
        msat[k][c] = msat[k][c] | (mcnt[k][c] == satv[k]);
      end
      high[c] = !lvl ? 0 : (ce ? high[c] + 1 : high[c]);
      prev[c] = lvl;
      meff[c] = mode_in[c];
    end
    mdone = timer;
    if (timer) mbank = !mbank;
    n_edge++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge ifclk);
    #1;
    check_eq("done_a",  32'(done_a), 32'(mdone));
    check_eq("bank_a",  32'(bank_a), 32'(mbank));
    check_eq("valid_a", 32'(if_a.rd_valid_o), 32'(p2v));
    if (p2v) check_eq("data_a", if_a.rd_dat_o, p2d[0]);
    check_eq("done_b",  32'(done_b), 32'(mdone));
    check_eq("bank_b",  32'(bank_b), 32'(mbank));
    check_eq("valid_b", 32'(if_b.rd_valid_o), 32'(p2v));
    if (p2v) check_eq("data_b", if_b.rd_dat_o, p2d[1]);
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, "_done_a"},  32'(done_a), 32'h0);
    check_eq({tag, "_bank_a"},  32'(bank_a), 32'h0);
    check_eq({tag, "_valid_a"}, 32'(if_a.rd_valid_o), 32'h0);
    check_eq({tag, "_dat_a"},   if_a.rd_dat_o, 32'h0);
    check_eq({tag, "_done_b"},  32'(done_b), 32'h0);
    check_eq({tag, "_valid_b"}, 32'(if_b.rd_valid_o), 32'h0);
    check_eq({tag, "_dat_b"},   if_b.rd_dat_o, 32'h0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] ea, input logic [31:0] eb);
    rd = 1'b1; adr = a;
    tick();
    rd = 1'b0;
    for (int unsigned i = 1; i < RD_LATENCY; i++) tick();
    check_eq("rd_valid_a", 32'(if_a.rd_valid_o), 32'h1);
    check_eq("rd_dir_a", if_a.rd_dat_o, ea);
    check_eq("rd_valid_b", 32'(if_b.rd_valid_o), 32'h1);
    check_eq("rd_dir_b", if_b.rd_dat_o, eb);
  endtask

  task automatic pulses(input int unsigned ch, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cnt_in[ch] = 1'b1; tick();
      cnt_in[ch] = 1'b0; tick();
    end
  endtask

  task automatic commit();
    timer = 1'b1; tick();
    timer = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cnt_in = '0; mode_in = '0; timer = 1'b0; rd = 1'b0; adr = '0;
    model_reset();
    #3;
    chk_reset("reset");
    @(posedge ifclk); #1;
    rst_n = 1'b1;

    // Edge mode, five pulses on ch2.
    pulses(2, 5);
    commit();
    check_eq("t1_done", 32'(done_a), 32'h1);
    check_eq("t1_bank", 32'(bank_a), 32'h1);
    do_read(8'd2, 32'h5, 32'h5);
    do_read(8'd0, 32'h0, 32'h0);
    do_read(8'd3, 32'h0, 32'h0);

    // Level mode, ch1 high for 20 cycles.
    mode_in = 4'b0010; tick();
    cnt_in[1] = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    cnt_in[1] = 1'b0; tick();
    commit();
    do_read(8'd1, 32'h14, 32'h4000000F);
    mode_in = 4'b0000; tick();

    // Stuck channel: ch0 held high across many check ticks.
    cnt_in[0] = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    commit();
    do_read(8'd0, 32'hC00003FF, 32'hC000000F);
    cnt_in[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    commit();
    do_read(8'd0, 32'hC00003FF, 32'hC000000F);
    commit();
    do_read(8'd0, 32'h0, 32'h0);

    // Saturation of the 4-bit instance.
    pulses(3, 20);
    commit();
    do_read(8'd3, 32'h14, 32'h4000000F);

    // Event coincident with the period end belongs to the new period.
    pulses(2, 3);
    cnt_in[2] = 1'b1; timer = 1'b1; tick();
    cnt_in[2] = 1'b0; timer = 1'b0; tick();
    do_read(8'd2, 32'h3, 32'h3);
    commit();
    do_read(8'd2, 32'h1, 32'h1);

    // Read issued the cycle before a commit returns the old bank.
    pulses(2, 7);
    rd = 1'b1; adr = 8'd2; tick();
    rd = 1'b0; timer = 1'b1; tick();
    timer = 1'b0;
    check_eq("pre_timer_rd", if_a.rd_dat_o, 32'h1);
    do_read(8'd2, 32'h7, 32'h7);
    do_read(8'd200, 32'h0, 32'h0);
    do_read(8'd50, 32'h0, 32'h0);

    // Back-to-back reads and back-to-back commits.
    for (int unsigned i = 0; i < 3; i++) begin
      rd = 1'b1; adr = 8'(i); tick();
    end
    rd = 1'b0; tick(); tick();
    timer = 1'b1; tick(); tick();
    timer = 1'b0;
    check_eq("b2b_done", 32'(done_a), 32'h1);
    tick();

    // Asynchronous reset mid-count and mid-read.
    pulses(3, 3);
    rd = 1'b1; adr = 8'd2; timer = 1'b1; tick();
    rst_n = 1'b0;
    #2;
    chk_reset("arst");
    rd = 1'b0; timer = 1'b0;
    @(posedge ifclk); #1;
    chk_reset("arst_hold");
    rst_n = 1'b1;
    model_reset();
    pulses(3, 4);
    commit();
    do_read(8'd3, 32'h4, 32'h4);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cnt_in[0]   = ($urandom_range(63) != 0);
      cnt_in[3:1] = 3'($urandom);
      if ($urandom_range(31) == 0) mode_in = 4'($urandom);
      timer = ($urandom_range(15) == 0);
      rd    = ($urandom_range(2) == 0);
      adr   = ($urandom_range(7) == 0) ? 8'd200 : 8'($urandom_range(7));
      tick();
    end
    timer = 1'b0; rd = 1'b0; cnt_in = '0;
    for (int i = 0; i < 3; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
